// File: rtl/hazard_stall_if.sv
// hazard_stall_if: IF/ID + ID/EX decode fields in, pipeline control and mult/div status out
interface hazard_stall_if #(
    parameter int STALL_W = 16
);
    logic [5:0]         id_opcode;
    logic [5:0]         id_funct;
    logic [4:0]         id_rs;
    logic [4:0]         id_rt;
    logic               id_nop;
    logic               ex_mem_read;
    logic [4:0]         ex_rt;
    logic               ex_branch_taken;
    logic               ex_jump;
    logic               pc_write;
    logic               ifid_write;
    logic               ifid_flush;
    logic               idex_nop;
    logic               muldiv_start;
    logic               muldiv_busy;
    logic [STALL_W-1:0] stall_cycles;

    modport master (
        output id_opcode, id_funct, id_rs, id_rt, id_nop,
        output ex_mem_read, ex_rt, ex_branch_taken, ex_jump,
        input  pc_write, ifid_write, ifid_flush, idex_nop,
        input  muldiv_start, muldiv_busy, stall_cycles
    );

    modport slave (
        input  id_opcode, id_funct, id_rs, id_rt, id_nop,
        input  ex_mem_read, ex_rt, ex_branch_taken, ex_jump,
        output pc_write, ifid_write, ifid_flush, idex_nop,
        output muldiv_start, muldiv_busy, stall_cycles
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use bubbles, redirect flushes and mult/div interlock between IF/ID and ID/EX
module hazard_stall_ctrl #(
    parameter int MULDIV_LAT = 32,
    parameter int CNT_W      = 6,
    parameter int STALL_W    = 16
) (
    input logic          clk,
    input logic          rst_n,
    hazard_stall_if.slave bus
);
    localparam logic [0:0] RUN     = 1'b0;
    localparam logic [0:0] MD_BUSY = 1'b1;

    logic [0:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [STALL_W-1:0] stall_cnt;
    logic uses_rs, uses_rt, is_md, is_hilo, loaduse, md_ilk, redirect, stall;

    // Decode the ID instruction and form the three hazard terms; a NOP word uses nothing
    always_comb begin
        uses_rs  = !bus.id_nop && bus.id_opcode != 6'd2;
        uses_rt  = !bus.id_nop && bus.id_opcode inside {6'd0, 6'd4, 6'd43};
        is_md    = !bus.id_nop && bus.id_opcode == 6'd0 && bus.id_funct inside {6'd24, 6'd25, 6'd26, 6'd27};
        is_hilo  = !bus.id_nop && bus.id_opcode == 6'd0 && bus.id_funct inside {6'd16, 6'd18};
        loaduse  = bus.ex_mem_read && bus.ex_rt != 5'd0 &&
                   ((uses_rs && bus.ex_rt == bus.id_rs) || (uses_rt && bus.ex_rt == bus.id_rt));
        md_ilk   = state == MD_BUSY && (is_md || is_hilo);
        redirect = bus.ex_branch_taken || bus.ex_jump;
        stall    = loaduse || md_ilk;
    end

    // Prioritised pipeline control: reset holds PC and bubbles, redirect beats stall beats start
    always_comb begin
        bus.pc_write     = rst_n && (redirect || !stall);
        bus.ifid_write   = rst_n && (redirect || !stall);
        bus.ifid_flush   = !rst_n || redirect;
        bus.idex_nop     = !rst_n || redirect || stall;
        bus.muldiv_start = rst_n && !redirect && !stall && state == RUN && is_md;
    end

    assign bus.muldiv_busy  = state == MD_BUSY;
    assign bus.stall_cycles = stall_cnt;

    // Busy window: counter loads LAT-1 on the start edge, state returns to RUN after it reaches zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else if (state == RUN) begin
            if (bus.muldiv_start) begin
                state <= MD_BUSY;
                cnt   <= CNT_W'(MULDIV_LAT - 1);
            end
        end else if (cnt == '0) begin
            state <= RUN;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    // Saturating count of cycles where the PC was held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (!bus.pc_write && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
    end
endmodule
